// File: rtl/cnn_act_pkg.sv
// Shared activation types and default sizes for the activation serializer slice.
package cnn_act_pkg;
    localparam int ACT_DATA_W = 8;
    localparam int ACT_OUT_CH = 16;
    localparam int ACT_DEPTH  = 4;

    typedef logic signed [ACT_DATA_W-1:0] act_t;
    typedef act_t act_vec_t [0:ACT_OUT_CH-1];
endpackage

// File: rtl/act_serializer_if.sv
// Bus between the ReLU stage, the serializer and the feature-map writeback.
// Optional ACT_SERIALIZER_LAST_EN adds the out_last end-of-vector marker.
interface act_serializer_if
    import cnn_act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int OUT_CH = ACT_OUT_CH,
    parameter int DEPTH  = ACT_DEPTH
);
    // Upstream pushes without backpressure; downstream beat = out_valid && out_ready.
    logic signed [DATA_W-1:0]        in_data [0:OUT_CH-1];
    logic                            in_valid;
    logic signed [DATA_W-1:0]        out_data;
    logic [$clog2(OUT_CH)-1:0]       out_ch;
    logic                            out_valid;
    logic                            out_ready;
    logic                            overflow;
    logic [$clog2(DEPTH+1)-1:0]      level;
`ifdef ACT_SERIALIZER_LAST_EN
    logic                            out_last;
`endif

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_ch, out_valid, overflow, level
`ifdef ACT_SERIALIZER_LAST_EN
        , input out_last
`endif
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_ch, out_valid, overflow, level
`ifdef ACT_SERIALIZER_LAST_EN
        , output out_last
`endif
    );
endinterface

// File: rtl/act_vec_fifo.sv
// Whole-vector FIFO; writes are refused when full, reads return one selected channel.
module act_vec_fifo
    import cnn_act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int OUT_CH = ACT_OUT_CH,
    parameter int DEPTH  = ACT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic signed [DATA_W-1:0]      wr_data [0:OUT_CH-1],
    input  logic                          rd_en,
    input  logic [$clog2(OUT_CH)-1:0]     rd_ch,
    output logic signed [DATA_W-1:0]      rd_elem,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          full,
    output logic                          empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic signed [DATA_W-1:0] mem [0:DEPTH-1][0:OUT_CH-1];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     push;
    logic                     pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_elem = mem[rd_ptr][rd_ch];

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < OUT_CH; i++) begin
                mem[wr_ptr][i] <= wr_data[i];
            end
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/act_serializer.sv
// Buffers parallel activation vectors and streams them one channel per beat.
// Define ACT_SERIALIZER_LAST_EN to drive out_last on the final channel of each vector.
module act_serializer
    import cnn_act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int OUT_CH = ACT_OUT_CH,
    parameter int DEPTH  = ACT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    act_serializer_if.slave  bus
);
    localparam int CH_W = $clog2(OUT_CH);

    logic [CH_W-1:0]          ch_q;
    logic                     overflow_q;
    logic                     full;
    logic                     empty;
    logic                     beat;
    logic                     last_ch;
    logic                     pop;
    logic signed [DATA_W-1:0] rd_elem;

    assign last_ch = (ch_q == CH_W'(OUT_CH-1));
    assign beat    = bus.out_valid && bus.out_ready;
    assign pop     = beat && last_ch;

    act_vec_fifo #(
        .DATA_W (DATA_W),
        .OUT_CH (OUT_CH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_data (bus.in_data),
        .rd_en   (pop),
        .rd_ch   (ch_q),
        .rd_elem (rd_elem),
        .level   (bus.level),
        .full    (full),
        .empty   (empty)
    );

    // Drop decision uses the registered fullness, so a same-cycle pop does not rescue it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (beat) ch_q <= last_ch ? '0 : ch_q + CH_W'(1);
            if (bus.in_valid && full) overflow_q <= 1'b1;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = rd_elem;
    assign bus.out_ch    = ch_q;
    assign bus.overflow  = overflow_q;
`ifdef ACT_SERIALIZER_LAST_EN
    assign bus.out_last  = bus.out_valid && last_ch;
`endif
endmodule
